// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// =============================================================================
// regfile_write_arbiter: round-robin arbiter for a single register-file write
// port. Optional lock bursts are enabled by defining REGFILE_ARB_LOCK_EN.
// Revision: 1.0
// =============================================================================
module regfile_write_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_sel,
  output logic [DATA_W-1:0]         rf_data,
  output logic [1:0]                grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || LOCK_MAX < 1) begin : g_param_check
    $error("regfile_write_arbiter: illegal NUM_REQ or LOCK_MAX");
  end

  logic [1:0]        r_last;
  logic              w_accept;
  logic [1:0]        w_idx;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_locked;
  logic [1:0]        w_owner;

  function automatic int rr_idx(input logic [1:0] last, input int k);
    return (int'(last) + k) % NUM_REQ;
  endfunction

`ifdef REGFILE_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t           r_state, w_state_nx;
  logic [1:0]       r_owner, w_owner_nx;
  logic [CNT_W-1:0] r_count, w_count_nx;
  logic             w_lock;

  assign w_locked = (r_state == LOCKED);
  assign w_owner  = r_owner;
`else
  assign w_locked = 1'b0;
  assign w_owner  = 2'd0;
`endif

  // Search starts just after the last grant; while locked only the owner may win.
  always_comb begin
    req_ready = '0;
    w_accept  = 1'b0;
    w_idx     = 2'd0;
    w_addr    = '0;
    w_data    = '0;
`ifdef REGFILE_ARB_LOCK_EN
    w_lock    = 1'b0;
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_accept && req_valid[rr_idx(r_last, k)] &&
          (!w_locked || rr_idx(r_last, k) == int'(w_owner))) begin
        w_accept                      = 1'b1;
        w_idx                         = 2'(rr_idx(r_last, k));
        req_ready[rr_idx(r_last, k)]  = 1'b1;
        w_addr = req_addr[rr_idx(r_last, k)*ADDR_W +: ADDR_W];
        w_data = req_data[rr_idx(r_last, k)*DATA_W +: DATA_W];
`ifdef REGFILE_ARB_LOCK_EN
        w_lock = req_lock[rr_idx(r_last, k)];
`endif
      end
    end
  end

`ifdef REGFILE_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= UNLOCKED;
      r_owner <= 2'd0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_owner <= w_owner_nx;
      r_count <= w_count_nx;
    end
  end

  // The beat that would reach LOCK_MAX releases the lock instead of counting.
  always_comb begin
    w_state_nx = r_state;
    w_owner_nx = r_owner;
    w_count_nx = r_count;
    if (w_accept) begin
      case (r_state)
        UNLOCKED: begin
          if (w_lock && LOCK_MAX > 1) begin
            w_state_nx = LOCKED;
            w_owner_nx = w_idx;
            w_count_nx = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (w_lock && (int'(r_count) + 1 < LOCK_MAX)) begin
            w_count_nx = r_count + CNT_W'(1);
          end else begin
            w_state_nx = UNLOCKED;
            w_count_nx = '0;
          end
        end
        default: begin
          w_state_nx = UNLOCKED;
          w_count_nx = '0;
        end
      endcase
    end
  end
`endif

  // Register 0 is read-only: the beat is accepted but never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_sel   <= '0;
      rf_data  <= '0;
      grant_id <= 2'd0;
      r_last   <= 2'(NUM_REQ - 1);
    end else begin
      rf_we <= w_accept && (w_addr != '0);
      if (w_accept) begin
        rf_sel   <= w_addr;
        rf_data  <= w_data;
        grant_id <= w_idx;
        r_last   <= w_idx;
      end
    end
  end

endmodule
`default_nettype wire
